// File: rtl/multicycle_control_unit_if.sv
// Instruction/flag inputs and datapath control outputs of the multicycle controller.
// master = controller side, slave = datapath side.
interface multicycle_control_unit_if #(
  parameter int ALUCTRL_W = 4
);
  logic [19:0]          Instr;
  logic [3:0]           ALUFlags;
  logic                 mem_ready;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegWrite;
  logic [1:0]           ResultSrc;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [3:0]           Flags;
  logic [3:0]           state;
  logic                 illegal;

  modport master (
    input  Instr, ALUFlags, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, state, illegal
  );

  modport slave (
    output Instr, ALUFlags, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, state, illegal
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM controller: DP 4, LDR 5, STR 4, B 3 cycles; FETCH/MEMRD/MEMWR
// hold while memory is not ready (only when USE_MEM_READY = 1).
module multicycle_control_unit #(
  parameter int ALUCTRL_W     = 4,
  parameter int USE_MEM_READY = 0,
  parameter int COND_EXEC     = 1
) (
  input  logic clk,
  input  logic reset,
  multicycle_control_unit_if.master bus
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q;
  logic       condex_q;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       rdy;
  logic       unused_instr;

  assign cond         = bus.Instr[19:16];
  assign op           = bus.Instr[15:14];
  assign funct        = bus.Instr[13:8];
  assign rd           = bus.Instr[7:4];
  assign cmd          = funct[4:1];
  assign unused_instr = ^bus.Instr[3:0];
  assign rdy          = bus.mem_ready || (USE_MEM_READY == 0);

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_hit, condex_now;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_hit = 1'b0;
    case (cond)
      4'b0000: cond_hit = flag_z;
      4'b0001: cond_hit = !flag_z;
      4'b0010: cond_hit = flag_c;
      4'b0011: cond_hit = !flag_c;
      4'b0100: cond_hit = flag_n;
      4'b0101: cond_hit = !flag_n;
      4'b0110: cond_hit = flag_v;
      4'b0111: cond_hit = !flag_v;
      4'b1000: cond_hit = flag_c && !flag_z;
      4'b1001: cond_hit = !flag_c || flag_z;
      4'b1010: cond_hit = (flag_n == flag_v);
      4'b1011: cond_hit = (flag_n != flag_v);
      4'b1100: cond_hit = !flag_z && (flag_n == flag_v);
      4'b1101: cond_hit = flag_z || (flag_n != flag_v);
      4'b1110: cond_hit = 1'b1;
      default: cond_hit = 1'b0;
    endcase
  end

  assign condex_now = (COND_EXEC == 0) ? 1'b1 : cond_hit;

  // cmd_arith selects whether C/V follow the ALU on a flag-setting op
  logic [ALUCTRL_W-1:0] alu_dec;
  logic                 cmd_ok, cmd_arith, is_cmp;

  always_comb begin
    alu_dec   = ALU_ADD;
    cmd_ok    = 1'b1;
    cmd_arith = 1'b0;
    is_cmp    = 1'b0;
    case (cmd)
      4'b0100: cmd_arith = 1'b1;
      4'b0010: begin alu_dec = ALU_SUB; cmd_arith = 1'b1; end
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      4'b1010: begin alu_dec = ALU_SUB; cmd_arith = 1'b1; is_cmp = 1'b1; end
      default: cmd_ok = 1'b0;
    endcase
  end

  logic                 pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]           result_src, alu_src_b;
  logic                 alu_src_a, illegal_c;
  logic [ALUCTRL_W-1:0] alu_ctl;

  always_comb begin
    state_d    = FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = ALU_ADD;
    illegal_c  = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = rdy;
        pc_write   = rdy;
        state_d    = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: begin state_d = FETCH; illegal_c = 1'b1; end
        endcase
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        state_d = rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = condex_q;
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = condex_q;
        state_d   = rdy ? FETCH : MEMWR;
      end
      EXECR, EXECI: begin
        alu_src_b = (state_q == EXECI) ? 2'b01 : 2'b00;
        alu_ctl   = alu_dec;
        illegal_c = !cmd_ok;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = condex_q && !is_cmp;
        pc_write  = condex_q && (rd == 4'd15);
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = condex_q;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE)
        condex_q <= condex_now;
      if ((state_q == EXECR || state_q == EXECI) && funct[0] && condex_q) begin
        flags_q[3:2] <= bus.ALUFlags[3:2];
        if (cmd_arith)
          flags_q[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  // Write strobes are killed combinationally so a reset mid-access writes nothing
  assign bus.PCWrite    = pc_write  && !reset;
  assign bus.MemWrite   = mem_write && !reset;
  assign bus.IRWrite    = ir_write  && !reset;
  assign bus.RegWrite   = reg_write && !reset;
  assign bus.illegal    = illegal_c && !reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b10, op == 2'b01};
  assign bus.Flags      = flags_q;
  assign bus.state      = state_q;

endmodule
